// File: rtl/cache_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_types
// Shared types for the cache-to-memory arbiter: FSM state encoding, the
// requester identity and default geometry of a cache line.
// Contents:
//   arb_state_t  ARB_IDLE / ARB_I_BUSY / ARB_D_BUSY / ARB_RESP
//   arb_src_t    SRC_I / SRC_D
//   ARB_LINE_W, ARB_ADDR_W, ARB_OFFSET_W  default parameter values
// ---------------------------------------------------------------------------
package arb_types;

  localparam int ARB_LINE_W   = 256;
  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_OFFSET_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/cache_mem_arbiter_select.sv
// ---------------------------------------------------------------------------
// cache_arb_select
// Combinational winner pick between the I-cache and D-cache requests.
// Build option: CACHE_ARB_RR_EN
//   undefined -> fixed priority, D wins every tie
//   defined   -> round-robin, a tie goes to the requester not granted last
// Ports:
//   i_req        I-cache request pending
//   d_req        D-cache request pending (read or write)
//   last_src     requester granted most recently (register lives in parent)
//   grant_valid  at least one request pending
//   grant_src    chosen requester, meaningful only with grant_valid
// ---------------------------------------------------------------------------
module cache_arb_select
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_src,
  output logic     grant_valid,
  output arb_src_t grant_src
);

  assign grant_valid = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
  always_comb begin
    grant_src = SRC_I;
    if (d_req && !i_req) begin
      grant_src = SRC_D;
    end else if (d_req && i_req) begin
      // Tie: hand the grant to whoever did not get the previous one.
      grant_src = (last_src == SRC_I) ? SRC_D : SRC_I;
    end
  end
`else
  // Fixed priority ignores history; a data miss stalls the memory stage,
  // so D always wins.
  logic unused_last_src;
  assign unused_last_src = (last_src == SRC_D);
  assign grant_src       = d_req ? SRC_D : SRC_I;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates I-cache line reads and D-cache line reads/write-backs onto a
// single burst memory port. One transaction in flight; the request is
// latched at grant so every pmem output comes straight from a register and
// is stable until pmem_resp.
// Build option: CACHE_ARB_RR_EN (round-robin tie breaking, see
// cache_arb_select); default build is fixed D-over-I priority.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   i_read, i_addr             I-cache read request
//   i_rdata, i_resp            returned line / one-cycle completion to I
//   d_read, d_write, d_addr,
//   d_wdata                    D-cache read / write-back request
//   d_rdata, d_resp            returned line / one-cycle completion to D
//   pmem_read, pmem_write,
//   pmem_addr, pmem_wdata      memory request (line aligned)
//   pmem_rdata, pmem_resp      memory read line / one-cycle completion
// ---------------------------------------------------------------------------
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int LINE_W   = ARB_LINE_W,
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int OFFSET_W = ARB_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // The requester identity is carried by the BUSY state itself and the op
  // by the registered strobes, so no separate id/op flops are needed.
  arb_state_t        state_reg,      state_next;
  arb_src_t          last_src_reg,   last_src_next;
  logic [ADDR_W-1:0] addr_reg,       addr_next;
  logic [LINE_W-1:0] wdata_reg,      wdata_next;
  logic [LINE_W-1:0] line_reg,       line_next;
  logic              pmem_read_reg,  pmem_read_next;
  logic              pmem_write_reg, pmem_write_next;
  logic              i_resp_reg,     i_resp_next;
  logic              d_resp_reg,     d_resp_next;

  logic     grant_valid;
  arb_src_t grant_src;

  cache_arb_select u_select (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_src    (last_src_reg),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  always_comb begin
    state_next      = state_reg;
    last_src_next   = last_src_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    line_next       = line_reg;
    pmem_read_next  = pmem_read_reg;
    pmem_write_next = pmem_write_reg;
    i_resp_next     = 1'b0;
    d_resp_next     = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (grant_valid) begin
          last_src_next = grant_src;
          if (grant_src == SRC_D) begin
            state_next      = ARB_D_BUSY;
            addr_next       = {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            // Write wins when both d_read and d_write are raised.
            pmem_write_next = d_write;
            pmem_read_next  = ~d_write;
            if (d_write) begin
              wdata_next = d_wdata;
            end
          end else begin
            state_next      = ARB_I_BUSY;
            addr_next       = {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            pmem_read_next  = 1'b1;
            pmem_write_next = 1'b0;
          end
        end
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        if (pmem_resp) begin
          state_next      = ARB_RESP;
          line_next       = pmem_rdata;
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
          i_resp_next     = (state_reg == ARB_I_BUSY);
          d_resp_next     = (state_reg == ARB_D_BUSY);
        end
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ARB_IDLE;
      last_src_reg   <= SRC_I;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      line_reg       <= '0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
      i_resp_reg     <= 1'b0;
      d_resp_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_src_reg   <= last_src_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      line_reg       <= line_next;
      pmem_read_reg  <= pmem_read_next;
      pmem_write_reg <= pmem_write_next;
      i_resp_reg     <= i_resp_next;
      d_resp_reg     <= d_resp_next;
    end
  end

  assign pmem_read  = pmem_read_reg;
  assign pmem_write = pmem_write_reg;
  assign pmem_addr  = addr_reg;
  assign pmem_wdata = wdata_reg;
  assign i_resp     = i_resp_reg;
  assign d_resp     = d_resp_reg;
  assign i_rdata    = line_reg;
  assign d_rdata    = line_reg;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates cache-line requests from the instruction cache and the data cache onto the single burst memory port behind the pipelined datapath. It sits directly downstream of both L1 caches, which serve the datapath's inst_* and data_* ports, and upstream of the cacheline adaptor. One transaction is in flight at a time. Requests are latched at grant, so pmem outputs are glitch-free and held stable until pmem_resp.

## Interface
- LINE_W, 256: cache line width in bits
- ADDR_W, 32: byte address width
- OFFSET_W, 5: line offset bits, log2(LINE_W/8)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- i_read  input  1  I-cache line read request
- i_addr  input  ADDR_W  I-cache request address
- i_rdata  output  LINE_W  line returned to I-cache
- i_resp  output  1  I-cache completion pulse
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write-back request
- d_addr  input  ADDR_W  D-cache request address
- d_wdata  input  LINE_W  D-cache write-back line
- d_rdata  output  LINE_W  line returned to D-cache
- d_resp  output  1  D-cache completion pulse
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_addr  output  ADDR_W  line-aligned memory address
- pmem_wdata  output  LINE_W  memory write line
- pmem_rdata  input  LINE_W  memory read line
- pmem_resp  input  1  memory completion, one cycle

## Operation
- States:
  - ARB_IDLE: no grant.
  - ARB_I_BUSY: instruction read in flight.
  - ARB_D_BUSY: data read or write in flight.
  - ARB_RESP: one-cycle completion to the granted cache.
- In ARB_IDLE, a D request (d_read|d_write) or an I request (i_read) is granted and latched on the edge.
- Latched fields: the requester ID, the op (read or write), the address {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, and d_wdata for writes.
- If d_read and d_write are both high, the op is a write.
- BUSY states drive pmem_read or pmem_write from the latched op, held until pmem_resp. pmem_addr and pmem_wdata come only from the latched registers.
- When pmem_resp is seen in a BUSY state, pmem_rdata is captured into the line buffer and the state moves to ARB_RESP.
- ARB_RESP asserts exactly one of i_resp/d_resp for one cycle, with {i,d}_rdata = line buffer, then returns to ARB_IDLE.
- i_rdata and d_rdata both always show the line buffer. Caches qualify them with their own resp.
- A requester must drop its request in the cycle after its resp. The arbiter re-samples requests only in ARB_IDLE.
- Requests that change while not granted are ignored until ARB_IDLE.

## Timing
- Reset (rst=0, any cycle, including mid-transaction):
  - State is ARB_IDLE; all outputs, the line buffer and the latched fields are 0.
  - An in-flight transaction is abandoned and no resp is issued.
  - The memory side must tolerate the strobe dropping.
- Latency, taking the request high in cycle t while in ARB_IDLE:
  - The pmem strobe rises in t+1.
  - With pmem_resp in cycle r ≥ t+1, the strobe is low from r+1 and the cache resp is high in r+1 only.
  - The next grant is possible in r+2.
- Minimum occupancy is 3 cycles per transaction (grant, one BUSY cycle with immediate pmem_resp, RESP).
- pmem_resp outside a BUSY state is ignored.

## Configuration
- CACHE_ARB_RR_EN undefined:
  - Fixed priority: D wins any tie in ARB_IDLE, because a data miss stalls the memory stage.
  - I can starve under back-to-back D traffic.
- CACHE_ARB_RR_EN defined:
  - Round-robin: a 1-bit last-granted register (reset to I) gives the tie to the requester not granted last.
  - A single pending requester is always granted immediately.

## Structure
- Shared package arb_types: enum arb_state_t {ARB_IDLE, ARB_I_BUSY, ARB_D_BUSY, ARB_RESP}, enum arb_src_t {SRC_I, SRC_D}, localparams LINE_W/OFFSET_W defaults.
- One sub-module: cache_arb_select, a combinational winner pick from (i_req, d_req, last_src). It contains the CACHE_ARB_RR_EN logic; the last_src register stays in the parent.

## Test plan
- Reset mid-read:
  - Stimulus: i_read with addr 0x0000_1044, pmem stalled 4 cycles, rst=0 for 1 cycle.
  - Response: pmem_read drops immediately and stays low, no i_resp, state ARB_IDLE.
- Single I read:
  - Stimulus: i_read at 0x0000_1044, pmem_resp after 3 cycles with rdata 0xA5…A5.
  - Response: pmem_addr 0x0000_1040, pmem_read high 3 cycles, i_resp exactly one cycle later with i_rdata 0xA5…A5, d_resp never high.
- D write-back:
  - Stimulus: d_write at 0x8000_003F, d_wdata = 256'h1234…; d_wdata changes after grant.
  - Response: pmem_addr 0x8000_0020, pmem_write high and pmem_wdata holding the original line until pmem_resp; d_resp one cycle later.
- Simultaneous I and D requests, fixed priority:
  - Stimulus: I and D requests in the same cycle, D read and I read both pending.
  - Response: D is served first; I is granted the cycle after d_resp + 1.
- Round-robin (CACHE_ARB_RR_EN):
  - Stimulus: four back-to-back ties.
  - Response: grants alternate D, I, D, I, with the first grant going to D since last_src resets to I.
- d_read and d_write both high:
  - Stimulus: d_read=1, d_write=1.
  - Response: pmem_write=1, pmem_read=0.
